// File: rtl/gf_mul_seq.sv
// ---------------------------------------------------------------------------
// gf_mul_seq
//
// Sequential GF(2^WIDTH) multiplier. It computes A*B modulo the reduction
// polynomial x^WIDTH + POLY with iterative shift-and-add (xtime) steps,
// BITS_PER_CYCLE steps per clock. A single instance can be shared by
// MixColumns, InvMixColumns and key-schedule logic in place of several
// fixed-constant multipliers.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid and ready are both 1.
//   Producers hold valid and data stable until that edge. Ready never depends
//   combinationally on valid: InReady is 1 exactly in IDLE and OutValid is 1
//   exactly in DONE, so one operation occupies the block from acceptance
//   until its result is consumed.
//
// Ports:
//   Clk       in   1      clock; all logic on the rising edge
//   Rst       in   1      synchronous active-high reset; aborts any operation
//   InValid   in   1      operands valid
//   InReady   out  1      block can accept operands (IDLE)
//   A         in   WIDTH  multiplicand, sampled only on the accept edge
//   B         in   WIDTH  multiplier, sampled only on the accept edge
//   OutValid  out  1      Product valid (DONE)
//   OutReady  in   1      consumer takes Product
//   Product   out  WIDTH  A*B mod (x^WIDTH + POLY); holds its last value
//   dbg_state out  2      current FSM state (debug observation only)
//
// Parameters:
//   WIDTH           field element width in bits (>= 2)
//   POLY            low WIDTH bits of the reduction polynomial
//   BITS_PER_CYCLE  multiplier bits consumed per clock; must divide WIDTH
// ---------------------------------------------------------------------------
module gf_mul_seq #(
    parameter int unsigned      WIDTH          = 8,
    parameter logic [WIDTH-1:0] POLY           = WIDTH'(8'h1B),
    parameter int unsigned      BITS_PER_CYCLE = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Product,
    output logic [1:0]       dbg_state
);

    // Reject configurations where the step count does not divide evenly.
    generate
        if (BITS_PER_CYCLE == 0 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
            $error("gf_mul_seq: BITS_PER_CYCLE must be nonzero and divide WIDTH");
        end
    endgenerate

    // Number of clocks spent in BUSY per operation.
    localparam int unsigned N     = (BITS_PER_CYCLE == 0) ? 1 : WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] product_q, product_d;

    // Values after applying this cycle's BITS_PER_CYCLE steps to the
    // working registers.
    logic [WIDTH-1:0] a_step;
    logic [WIDTH-1:0] b_step;
    logic [WIDTH-1:0] acc_step;

    // Unrolled xtime steps. Each step conditionally adds the current
    // multiplicand, then multiplies it by x with reduction, then moves to the
    // next multiplier bit. Steps chain combinationally within one clock.
    always_comb begin
        a_step   = a_q;
        b_step   = b_q;
        acc_step = acc_q;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            if (b_step[0]) begin
                acc_step = acc_step ^ a_step;
            end
            // The reduction decision uses the MSB before the shift drops it.
            a_step = {a_step[WIDTH-2:0], 1'b0} ^ (a_step[WIDTH-1] ? POLY : '0);
            b_step = b_step >> 1;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            S_IDLE: begin
                if (InValid) begin
                    a_d     = A;
                    b_d     = B;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end

            S_BUSY: begin
                a_d   = a_step;
                b_d   = b_step;
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Last group of steps: publish the finished accumulator.
                    product_d = acc_step;
                    state_d   = S_DONE;
                end
            end

            S_DONE: begin
                // Returning to IDLE does not accept on the same edge, even if
                // InValid is high; acceptance waits for the next edge.
                if (OutReady) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign InReady   = (state_q == S_IDLE);
    assign OutValid  = (state_q == S_DONE);
    assign Product   = product_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_gf_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_gf_mul_seq
//
// Four multiplier instances share clock and reset:
//   idx 0: WIDTH=8, POLY=0x1B, BITS_PER_CYCLE=1 (latency 8)
//   idx 1: WIDTH=8, POLY=0x1B, BITS_PER_CYCLE=8 (latency 1)
//   idx 2: WIDTH=8, POLY=0x1B, BITS_PER_CYCLE=4 (latency 2)
//   idx 3: WIDTH=4, POLY=0x3,  BITS_PER_CYCLE=1 (latency 4)
// Expected products come from fixed vectors or from a carry-less multiply
// followed by polynomial long division.
// ---------------------------------------------------------------------------
module tb_gf_mul_seq;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       in_valid  [4];
    logic       in_ready  [4];
    logic       out_valid [4];
    logic       out_ready [4];
    logic [7:0] a         [4];
    logic [7:0] b         [4];
    logic [7:0] product   [4];
    logic [1:0] dbg_state [4];
    logic [3:0] product4;

    int n_vec = 0;
    int n_err = 0;

    gf_mul_seq #(.WIDTH(8), .POLY(8'h1B), .BITS_PER_CYCLE(1)) u_bpc1 (
        .Clk(clk), .Rst(rst), .InValid(in_valid[0]), .InReady(in_ready[0]),
        .A(a[0]), .B(b[0]), .OutValid(out_valid[0]), .OutReady(out_ready[0]),
        .Product(product[0]), .dbg_state(dbg_state[0]));

    gf_mul_seq #(.WIDTH(8), .POLY(8'h1B), .BITS_PER_CYCLE(8)) u_bpc8 (
        .Clk(clk), .Rst(rst), .InValid(in_valid[1]), .InReady(in_ready[1]),
        .A(a[1]), .B(b[1]), .OutValid(out_valid[1]), .OutReady(out_ready[1]),
        .Product(product[1]), .dbg_state(dbg_state[1]));

    gf_mul_seq #(.WIDTH(8), .POLY(8'h1B), .BITS_PER_CYCLE(4)) u_bpc4 (
        .Clk(clk), .Rst(rst), .InValid(in_valid[2]), .InReady(in_ready[2]),
        .A(a[2]), .B(b[2]), .OutValid(out_valid[2]), .OutReady(out_ready[2]),
        .Product(product[2]), .dbg_state(dbg_state[2]));

    gf_mul_seq #(.WIDTH(4), .POLY(4'h3), .BITS_PER_CYCLE(1)) u_w4 (
        .Clk(clk), .Rst(rst), .InValid(in_valid[3]), .InReady(in_ready[3]),
        .A(a[3][3:0]), .B(b[3][3:0]), .OutValid(out_valid[3]), .OutReady(out_ready[3]),
        .Product(product4), .dbg_state(dbg_state[3]));

    assign product[3] = {4'h0, product4};

    // ---------------- configuration lookup ----------------
    function automatic int lat_of(input int idx);
        case (idx)
            0:       return 8;
            1:       return 1;
            2:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int width_of(input int idx);
        return (idx == 3) ? 4 : 8;
    endfunction

    function automatic logic [7:0] poly_of(input int idx);
        return (idx == 3) ? 8'h03 : 8'h1B;
    endfunction

    // ---------------- reference model ----------------
    // Full carry-less product, then remainder modulo x^w + poly by long division.
    function automatic logic [7:0] gf_ref(input logic [7:0] x, input logic [7:0] y,
                                          input int w, input logic [7:0] poly);
        logic [15:0] p;
        logic [15:0] red;
        p   = 16'h0;
        red = 16'(poly) | (16'd1 << w);
        for (int i = 0; i < w; i++) begin
            if (y[i]) p = p ^ (16'(x) << i);
        end
        for (int i = 2 * w - 2; i >= w; i--) begin
            if (p[i]) p = p ^ (red << (i - w));
        end
        return p[7:0];
    endfunction

    // ---------------- driver tasks ----------------
    // Called at #1 after an edge with the instance in IDLE.
    task automatic start_op(input int idx, input logic [7:0] av, input logic [7:0] bv);
        a[idx]        = av;
        b[idx]        = bv;
        in_valid[idx] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[idx] = 1'b0;
        // Scramble operands: they must only be sampled on the accept edge.
        a[idx] = 8'($urandom);
        b[idx] = 8'($urandom);
    endtask

    // Counts edges after acceptance until OutValid is seen (bounded).
    task automatic wait_valid(input int idx, output int lat);
        lat = 0;
        while (out_valid[idx] !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_op(input int idx);
        out_ready[idx] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int idx, input logic [7:0] av, input logic [7:0] bv,
                          output logic [7:0] prod, output int lat);
        start_op(idx, av, bv);
        wait_valid(idx, lat);
        prod = product[idx];
        finish_op(idx);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic seen;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (in_ready[i] !== 1'b1) begin
                n_err++;
                $display("FAIL reset_in_ready idx%0d got %b want 1", i, in_ready[i]);
            end
            n_vec++;
            if (out_valid[i] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_out_valid idx%0d got %b want 0", i, out_valid[i]);
            end
            n_vec++;
            if (product[i] !== 8'h00) begin
                n_err++;
                $display("FAIL reset_product idx%0d got 0x%0h want 0x0", i, product[i]);
            end
        end

        // Abort an operation in flight.
        start_op(0, 8'h57, 8'h83);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_vec++;
        if (in_ready[0] !== 1'b1) begin
            n_err++;
            $display("FAIL abort_in_ready got %b want 1", in_ready[0]);
        end
        seen = out_valid[0];
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid[0] === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL abort_out_valid rose got %b want 0", seen);
        end
        n_vec++;
        if (product[0] !== 8'h00) begin
            n_err++;
            $display("FAIL abort_product got 0x%0h want 0x0", product[0]);
        end
    endtask

    task automatic test_xtime();
        logic [7:0] xa [4] = '{8'd123, 8'd255, 8'd234, 8'd23};
        logic [7:0] xe [4] = '{8'd246, 8'd229, 8'd207, 8'd46};
        logic [7:0] p;
        logic [7:0] exp_v;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(0, xa[i], 8'h02, p, lat);
            n_vec++;
            if (p !== xe[i]) begin
                n_err++;
                $display("FAIL xtime A=%0d got %0d want %0d", xa[i], p, xe[i]);
            end
            n_vec++;
            if (lat !== 8) begin
                n_err++;
                $display("FAIL xtime_latency A=%0d got %0d want 8", xa[i], lat);
            end
        end
        // Every A against the plain xtime rule.
        for (int v = 0; v < 256; v++) begin
            run_op(0, 8'(v), 8'h02, p, lat);
            exp_v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
            n_vec++;
            if (p !== exp_v) begin
                n_err++;
                $display("FAIL xtime_all A=0x%0h got 0x%0h want 0x%0h", v, p, exp_v);
            end
        end
    endtask

    task automatic test_fips();
        logic [7:0] fa [5] = '{8'h57, 8'h57, 8'h53, 8'h00, 8'hA5};
        logic [7:0] fb [5] = '{8'h83, 8'h13, 8'hCA, 8'hA5, 8'h01};
        logic [7:0] fe [5] = '{8'hC1, 8'hFE, 8'h01, 8'h00, 8'hA5};
        logic [7:0] p;
        int lat;
        for (int idx = 0; idx < 3; idx++) begin
            for (int i = 0; i < 5; i++) begin
                run_op(idx, fa[i], fb[i], p, lat);
                n_vec++;
                if (p !== fe[i]) begin
                    n_err++;
                    $display("FAIL fips idx%0d 0x%0h*0x%0h got 0x%0h want 0x%0h",
                             idx, fa[i], fb[i], p, fe[i]);
                end
                n_vec++;
                if (lat !== lat_of(idx)) begin
                    n_err++;
                    $display("FAIL fips_latency idx%0d got %0d want %0d", idx, lat, lat_of(idx));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready[0] = 1'b0;
        start_op(0, 8'h57, 8'h83);
        wait_valid(0, lat);
        n_vec++;
        if (lat !== 8) begin
            n_err++;
            $display("FAIL bp_latency got %0d want 8", lat);
        end
        for (int c = 0; c < 20; c++) begin
            in_valid[0] = c[0];
            a[0] = 8'($urandom);
            b[0] = 8'($urandom);
            @(posedge clk);
            #1;
            n_vec++;
            if (out_valid[0] !== 1'b1) begin
                n_err++;
                $display("FAIL bp_out_valid cycle %0d got %b want 1", c, out_valid[0]);
            end
            n_vec++;
            if (product[0] !== 8'hC1) begin
                n_err++;
                $display("FAIL bp_product cycle %0d got 0x%0h want 0xc1", c, product[0]);
            end
            n_vec++;
            if (in_ready[0] !== 1'b0) begin
                n_err++;
                $display("FAIL bp_in_ready cycle %0d got %b want 0", c, in_ready[0]);
            end
        end
        // Release with new operands already offered: not accepted on this edge.
        a[0] = 8'h53;
        b[0] = 8'hCA;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (out_valid[0] !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release_out_valid got %b want 0", out_valid[0]);
        end
        n_vec++;
        if (in_ready[0] !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release_idle in_ready got %b want 1", in_ready[0]);
        end
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        n_vec++;
        if (in_ready[0] !== 1'b0) begin
            n_err++;
            $display("FAIL bp_next_accept in_ready got %b want 0", in_ready[0]);
        end
        wait_valid(0, lat);
        n_vec++;
        if (product[0] !== 8'h01) begin
            n_err++;
            $display("FAIL bp_next_product got 0x%0h want 0x1", product[0]);
        end
        finish_op(0);
    endtask

    task automatic test_width4();
        logic [7:0] p;
        int lat;
        run_op(3, 8'h07, 8'h09, p, lat);
        n_vec++;
        if (p !== 8'h0A) begin
            n_err++;
            $display("FAIL w4 0x7*0x9 got 0x%0h want 0xa", p);
        end
        n_vec++;
        if (lat !== 4) begin
            n_err++;
            $display("FAIL w4_latency got %0d want 4", lat);
        end
        run_op(3, 8'h0F, 8'h0F, p, lat);
        n_vec++;
        if (p !== 8'h0A) begin
            n_err++;
            $display("FAIL w4 0xF*0xF got 0x%0h want 0xa", p);
        end
        n_vec++;
        if (lat !== 4) begin
            n_err++;
            $display("FAIL w4_latency got %0d want 4", lat);
        end
    endtask

    task automatic test_random();
        logic [7:0] av;
        logic [7:0] bv;
        logic [7:0] mask;
        logic [7:0] p;
        logic [7:0] exp_v;
        int lat;
        int count;
        int stall;
        for (int idx = 0; idx < 4; idx++) begin
            count = (idx == 1 || idx == 2) ? 1000 : 300;
            mask  = (width_of(idx) == 8) ? 8'hFF : 8'h0F;
            for (int k = 0; k < count; k++) begin
                av = 8'($urandom) & mask;
                bv = 8'($urandom) & mask;
                exp_v = gf_ref(av, bv, width_of(idx), poly_of(idx));
                start_op(idx, av, bv);
                wait_valid(idx, lat);
                p = product[idx];
                n_vec++;
                if (p !== exp_v) begin
                    n_err++;
                    $display("FAIL rand idx%0d 0x%0h*0x%0h got 0x%0h want 0x%0h",
                             idx, av, bv, p, exp_v);
                end
                n_vec++;
                if (lat !== lat_of(idx)) begin
                    n_err++;
                    $display("FAIL rand_latency idx%0d got %0d want %0d", idx, lat, lat_of(idx));
                end
                // Short random stall before consuming the result.
                stall = $urandom_range(0, 3);
                out_ready[idx] = 1'b0;
                repeat (stall) begin
                    @(posedge clk);
                    #1;
                end
                n_vec++;
                if (out_valid[idx] !== 1'b1 || product[idx] !== exp_v) begin
                    n_err++;
                    $display("FAIL rand_stall idx%0d valid %b product 0x%0h want valid 1 product 0x%0h",
                             idx, out_valid[idx], product[idx], exp_v);
                end
                finish_op(idx);
            end
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
            a[i]         = 8'h00;
            b[i]         = 8'h00;
        end
        test_reset();
        test_xtime();
        test_fips();
        test_backpressure();
        test_width4();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
